timer_arbiter: RTL and testbench

Round-robin controller that shares one millisecond countdown timer among up to N_REQ requesters. Each requester asks for a delay in ms. The arbiter grants one requester at a time, loads the shared timer with that requester's duration, runs it in count-down mode, and returns a one-cycle `done` pulse to the owner on expiry. It sits between game/UI sequencing logic and the single `timer` instance, and is the only block that drives the timer's control ports.

---
 rtl/timer_arbiter.sv | 127 ++++++++++++
 tb/tb_timer_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Round-robin owner of a single shared millisecond countdown timer.
// One requester at a time gets the timer loaded with its duration and receives a done pulse on expiry.
module timer_arbiter #(
    parameter int N_REQ  = 4,
    parameter int MAX_MS = 2000,
    parameter int W      = $clog2(MAX_MS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_ms,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic               tmr_reset,
    output logic               tmr_up,
    output logic [W-1:0]       tmr_start_value,
    output logic               tmr_run,
    input  logic [W-1:0]       tmr_value
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [IW-1:0]   last_reg, last_next;
    logic [W-1:0]    start_reg, start_next;

    logic [W-1:0]    dur [N_REQ];
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW:0]     cand;

    // Durations are clamped here so the latched value is always in range;
    // compared one bit wider so a power-of-two MAX_MS does not wrap to zero.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : gen_dur
            assign dur[gi] = ({1'b0, req_ms[gi*W +: W]} >= (W+1)'(MAX_MS))
                           ? W'(MAX_MS - 1) : req_ms[gi*W +: W];
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest set bit after last wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = {1'b0, last_reg} + (IW+1)'(off);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (req[cand[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            owner_reg <= '0;
            last_reg  <= IW'(N_REQ - 1);
            start_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            start_reg <= start_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        start_next = start_reg;
        case (state_reg)
            S_IDLE: begin
                if (pick_valid) begin
                    owner_next = pick_idx;
                    start_next = dur[pick_idx];
                    state_next = (dur[pick_idx] == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: state_next = S_ARM;
            S_ARM:  state_next = S_RUN;
            S_RUN: begin
                // A withdrawn request wins over a simultaneous expiry.
                if (!req[owner_reg]) begin
                    state_next = S_IDLE;
                    last_next  = owner_reg;
                end else if (tmr_value == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                last_next  = owner_reg;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : gen_onehot
            assign grant[gi] = (state_reg != S_IDLE) && (owner_reg == IW'(gi));
            assign done[gi]  = (state_reg == S_DONE) && (owner_reg == IW'(gi));
        end
    endgenerate

    assign busy            = (state_reg != S_IDLE);
    assign tmr_reset       = (state_reg == S_LOAD);
    assign tmr_run         = (state_reg == S_RUN);
    assign tmr_up          = 1'b0;
    assign tmr_start_value = start_reg;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios plus a randomized run against a round-robin model,
// with a behavioural millisecond timer (4 clocks per ms) attached to the timer control ports.
module tb_timer_arbiter;

    localparam int N_REQ  = 4;
    localparam int MAX_MS = 2000;
    localparam int W      = $clog2(MAX_MS);
    localparam int CPM    = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] req_ms;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   done;
    logic               busy;
    logic               tmr_reset;
    logic               tmr_up;
    logic [W-1:0]       tmr_start_value;
    logic               tmr_run;
    logic [W-1:0]       tmr_value;

    int pre;
    int rst_pulses = 0;
    int chk_cnt    = 0;
    int pass_cnt   = 0;

    timer_arbiter #(.N_REQ(N_REQ), .MAX_MS(MAX_MS)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_ms(req_ms),
        .grant(grant),
        .done(done),
        .busy(busy),
        .tmr_reset(tmr_reset),
        .tmr_up(tmr_up),
        .tmr_start_value(tmr_start_value),
        .tmr_run(tmr_run),
        .tmr_value(tmr_value)
    );

    always #5 clk = ~clk;

    // Millisecond countdown timer seen by the arbiter.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_value <= '0;
            pre       <= 0;
        end else if (tmr_reset) begin
            tmr_value <= tmr_start_value;
            pre       <= 0;
        end else if (tmr_run && tmr_value != '0) begin
            if (pre == CPM - 1) begin
                pre       <= 0;
                tmr_value <= tmr_value - 1'b1;
            end else begin
                pre <= pre + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (tmr_reset === 1'b1) rst_pulses <= rst_pulses + 1;
    end

    function automatic int rr_pick(input bit [N_REQ-1:0] m, input int last);
        for (int off = 1; off <= N_REQ; off++) begin
            if (m[(last + off) % N_REQ]) return (last + off) % N_REQ;
        end
        return 0;
    endfunction

    function automatic int clamp_ms(input int v);
        return (v >= MAX_MS) ? MAX_MS - 1 : v;
    endfunction

    function automatic int rand_ms();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 3) return 0;
        if (r < 5) return int'($urandom_range(MAX_MS, (1 << W) - 1));
        return int'($urandom_range(1, 5));
    endfunction

    task automatic set_ms(input int i, input int v);
        req_ms[i*W +: W] = W'(v);
    endtask

    task automatic do_reset;
        reset  = 1'b1;
        req    = '0;
        req_ms = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        bit ok;
        reset  = 1'b1;
        req    = '0;
        req_ms = '0;
        @(negedge clk);
        chk_cnt++;
        if ({grant, done, busy, tmr_reset, tmr_run, tmr_up, tmr_start_value} !== '0)
            $display("FAIL reset_outputs: got grant=%b done=%b busy=%b rst=%b run=%b up=%b start=%0d, need all 0",
                     grant, done, busy, tmr_reset, tmr_run, tmr_up, tmr_start_value);
        else pass_cnt++;
        reset = 1'b0;
        set_ms(0, 5);
        req = 4'b0001;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tmr_run === 1'b1) begin ok = 1'b1; break; end
        end
        chk_cnt++;
        if (!ok) $display("FAIL reset_reach_run: tmr_run=%b, need 1 within 10 cycles", tmr_run);
        else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        chk_cnt++;
        if ({grant, done, busy, tmr_reset, tmr_run, tmr_up, tmr_start_value} !== '0)
            $display("FAIL async_reset_outputs: got grant=%b done=%b busy=%b rst=%b run=%b start=%0d, need all 0",
                     grant, done, busy, tmr_reset, tmr_run, tmr_start_value);
        else pass_cnt++;
        req = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0 || grant !== '0)
            $display("FAIL post_reset_idle: busy=%b grant=%b, need 0/0000", busy, grant);
        else pass_cnt++;
    endtask

    task automatic test_single;
        int lat;
        bit ok;
        do_reset;
        set_ms(0, 5);
        req = 4'b0001;
        @(negedge clk);
        chk_cnt++;
        if (grant !== 4'b0001 || busy !== 1'b1 || tmr_reset !== 1'b1 || tmr_run !== 1'b0)
            $display("FAIL single_load: grant=%b busy=%b rst=%b run=%b, need 0001/1/1/0",
                     grant, busy, tmr_reset, tmr_run);
        else pass_cnt++;
        chk_cnt++;
        if (tmr_start_value !== W'(5))
            $display("FAIL single_start: start=%0d, need 5", tmr_start_value);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (tmr_reset !== 1'b0 || tmr_run !== 1'b0)
            $display("FAIL single_arm: rst=%b run=%b, need 0/0", tmr_reset, tmr_run);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (tmr_run !== 1'b1 || tmr_up !== 1'b0)
            $display("FAIL single_run: run=%b up=%b, need 1/0", tmr_run, tmr_up);
        else pass_cnt++;
        lat = 2;
        ok  = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (done !== '0) begin ok = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        chk_cnt++;
        if (!ok || done !== 4'b0001 || lat < 5*CPM + 2 || lat > 5*CPM + 5)
            $display("FAIL single_done: done=%b after %0d cycles, need 0001 after %0d..%0d",
                     done, lat, 5*CPM + 2, 5*CPM + 5);
        else pass_cnt++;
        req = '0;
        @(negedge clk);
        chk_cnt++;
        if (done !== '0 || grant !== '0 || busy !== 1'b0)
            $display("FAIL single_release: done=%b grant=%b busy=%b, need 0000/0000/0", done, grant, busy);
        else pass_cnt++;
    endtask

    task automatic test_round_robin;
        int order[9];
        bit ok;
        order = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
        do_reset;
        for (int i = 0; i < N_REQ; i++) set_ms(i, 1);
        req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            ok = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (grant !== '0) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            chk_cnt++;
            if (!ok || grant !== 4'(1 << order[k]))
                $display("FAIL rr_grant[%0d]: grant=%b, need %b", k, grant, 4'(1 << order[k]));
            else pass_cnt++;
            ok = 1'b0;
            for (int c = 0; c < 30; c++) begin
                if (done !== '0) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            chk_cnt++;
            if (!ok || done !== 4'(1 << order[k]))
                $display("FAIL rr_done[%0d]: done=%b, need %b", k, done, 4'(1 << order[k]));
            else pass_cnt++;
            if (k == 4) req[1] = 1'b0;
            @(negedge clk);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_cancel;
        bit ok;
        do_reset;
        set_ms(2, 5);
        req = 4'b0100;
        @(negedge clk);
        chk_cnt++;
        if (grant !== 4'b0100) $display("FAIL cancel_grant: grant=%b, need 0100", grant);
        else pass_cnt++;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (tmr_run === 1'b1 && tmr_value === W'(3)) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk_cnt++;
        if (!ok) $display("FAIL cancel_reach: run=%b value=%0d, need run with value 3", tmr_run, tmr_value);
        else pass_cnt++;
        set_ms(0, 1);
        set_ms(3, 1);
        req = 4'b1001;
        @(negedge clk);
        chk_cnt++;
        if (tmr_run !== 1'b0 || busy !== 1'b0 || done !== '0)
            $display("FAIL cancel_exit: run=%b busy=%b done=%b, need 0/0/0000", tmr_run, busy, done);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (grant !== 4'b1000) $display("FAIL cancel_next: grant=%b, need 1000", grant);
        else pass_cnt++;
        req = '0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_zero;
        int rp0;
        do_reset;
        set_ms(2, 0);
        req = 4'b0100;
        rp0 = rst_pulses;
        @(negedge clk);
        chk_cnt++;
        if (done !== 4'b0100 || grant !== 4'b0100 || tmr_reset !== 1'b0)
            $display("FAIL zero_done: done=%b grant=%b rst=%b, need 0100/0100/0", done, grant, tmr_reset);
        else pass_cnt++;
        req = '0;
        @(negedge clk);
        chk_cnt++;
        if (done !== '0 || busy !== 1'b0 || rst_pulses != rp0)
            $display("FAIL zero_after: done=%b busy=%b load_pulses=%0d, need 0000/0/0",
                     done, busy, rst_pulses - rp0);
        else pass_cnt++;
    endtask

    task automatic test_collision;
        bit ok;
        do_reset;
        set_ms(1, 1);
        req = 4'b0010;
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tmr_run === 1'b1 && tmr_value === '0) begin ok = 1'b1; break; end
        end
        chk_cnt++;
        if (!ok) $display("FAIL collide_reach: run=%b value=%0d, need run with value 0", tmr_run, tmr_value);
        else pass_cnt++;
        req = '0;
        @(negedge clk);
        chk_cnt++;
        if (done !== '0 || busy !== 1'b0)
            $display("FAIL collide_exit: done=%b busy=%b, need 0000/0", done, busy);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (done !== '0) $display("FAIL collide_late: done=%b, need 0000", done);
        else pass_cnt++;
    endtask

    task automatic test_random;
        bit [N_REQ-1:0] pend;
        int  m_last, exp_o, exp_sv, rp0, cw, budget;
        int  m_ms[N_REQ];
        bit  ok, cancel;
        do_reset;
        pend   = '0;
        m_last = N_REQ - 1;
        for (int t = 0; t < 60; t++) begin
            ok = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (busy === 1'b0) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            chk_cnt++;
            if (!ok) $display("FAIL rand_idle[%0d]: busy=%b, need 0", t, busy);
            else pass_cnt++;
            pend = pend | 4'($urandom_range(0, 15));
            if (pend == '0) pend[$urandom_range(0, N_REQ-1)] = 1'b1;
            for (int i = 0; i < N_REQ; i++) begin
                if (pend[i]) begin
                    m_ms[i] = rand_ms();
                    set_ms(i, m_ms[i]);
                end
            end
            req    = pend;
            exp_o  = rr_pick(pend, m_last);
            exp_sv = clamp_ms(m_ms[exp_o]);
            rp0    = rst_pulses;
            @(negedge clk);
            chk_cnt++;
            if (grant !== 4'(1 << exp_o))
                $display("FAIL rand_grant[%0d]: grant=%b, need %b (req=%b)", t, grant, 4'(1 << exp_o), pend);
            else pass_cnt++;
            chk_cnt++;
            if (tmr_start_value !== W'(exp_sv))
                $display("FAIL rand_start[%0d]: start=%0d, need %0d", t, tmr_start_value, exp_sv);
            else pass_cnt++;
            m_ms[exp_o] = rand_ms();
            set_ms(exp_o, m_ms[exp_o]);
            cancel = (exp_sv > 20) || (exp_sv != 0 && $urandom_range(0, 3) == 0);
            if (cancel) begin
                cw = (exp_sv * CPM > 20) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, exp_sv * CPM));
                ok = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    if (tmr_run === 1'b1) begin ok = 1'b1; break; end
                    @(negedge clk);
                end
                chk_cnt++;
                if (!ok) $display("FAIL rand_run[%0d]: run=%b, need 1", t, tmr_run);
                else pass_cnt++;
                repeat (cw) @(negedge clk);
                pend[exp_o] = 1'b0;
                req = pend;
                @(negedge clk);
                chk_cnt++;
                if (busy !== 1'b0 || tmr_run !== 1'b0 || done !== '0)
                    $display("FAIL rand_cancel[%0d]: busy=%b run=%b done=%b, need 0/0/0000", t, busy, tmr_run, done);
                else pass_cnt++;
                chk_cnt++;
                if (rst_pulses - rp0 != 1)
                    $display("FAIL rand_load_pulses[%0d]: %0d pulses, need 1", t, rst_pulses - rp0);
                else pass_cnt++;
            end else begin
                budget = exp_sv * CPM + 20;
                ok = 1'b0;
                for (int c = 0; c < budget; c++) begin
                    if (done !== '0) begin ok = 1'b1; break; end
                    @(negedge clk);
                end
                chk_cnt++;
                if (!ok || done !== 4'(1 << exp_o))
                    $display("FAIL rand_done[%0d]: done=%b, need %b", t, done, 4'(1 << exp_o));
                else pass_cnt++;
                chk_cnt++;
                if (tmr_start_value !== W'(exp_sv))
                    $display("FAIL rand_start_hold[%0d]: start=%0d, need %0d", t, tmr_start_value, exp_sv);
                else pass_cnt++;
                chk_cnt++;
                if (rst_pulses - rp0 != ((exp_sv == 0) ? 0 : 1))
                    $display("FAIL rand_load_pulses[%0d]: %0d pulses, need %0d", t, rst_pulses - rp0,
                             (exp_sv == 0) ? 0 : 1);
                else pass_cnt++;
                if ($urandom_range(0, 1) == 0) pend[exp_o] = 1'b0;
                req = pend;
                @(negedge clk);
                chk_cnt++;
                if (done !== '0) $display("FAIL rand_done_width[%0d]: done=%b, need 0000", t, done);
                else pass_cnt++;
            end
            m_last = exp_o;
        end
        req = '0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_cancel;
        test_zero;
        test_collision;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
